// File: rtl/hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl_if
// Description : Signal bundle between the pipeline stages (ID/EX/fetch) and
//               the hazard/sequencing controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface hazard_ctrl_if #(
    parameter int CNT_W = 16
) ();
    // Observations from the ID and EX stages
    logic             id_valid;
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic             id_uses_rs1;
    logic             id_uses_rs2;
    logic             ex_valid;
    logic             ex_is_load;
    logic [4:0]       ex_rd;
    logic             ex_busy;
    logic             ex_redirect;
    logic [31:0]      ex_target;
    logic             halt_req;

    // Controls toward fetch and the ID/EX register
    logic             stall;
    logic             issue_nop;
    logic             jmp;
    logic [31:0]      jmp_pc;
    logic             id_ex_bubble;
    logic             id_ex_hold;
    logic             flush_id;
    logic             halt_ack;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    // Controller side: watches the stages, drives the sequencing controls
    modport master (
        input  id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
        input  ex_valid, ex_is_load, ex_rd, ex_busy, ex_redirect, ex_target,
        input  halt_req,
        output stall, issue_nop, jmp, jmp_pc, id_ex_bubble, id_ex_hold,
        output flush_id, halt_ack, stall_cnt, flush_cnt
    );

    // Pipeline side: reports stage contents, obeys the sequencing controls
    modport slave (
        output id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
        output ex_valid, ex_is_load, ex_rd, ex_busy, ex_redirect, ex_target,
        output halt_req,
        input  stall, issue_nop, jmp, jmp_pc, id_ex_bubble, id_ex_hold,
        input  flush_id, halt_ack, stall_cnt, flush_cnt
    );
endinterface
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl
// Description : RV32IC front-end sequencing controller. Resolves load-use
//               hazards, EX redirects with a post-redirect NOP window,
//               multi-cycle EX waits and debug halt/drain; counts stall
//               cycles and taken redirects.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctrl #(
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 16
) (
    input  wire logic      clk,
    input  wire logic      reset,
    hazard_ctrl_if.master  bus
);

    localparam logic [2:0] c_RUN     = 3'd0;
    localparam logic [2:0] c_FLUSH   = 3'd1;
    localparam logic [2:0] c_MC_WAIT = 3'd2;
    localparam logic [2:0] c_DRAIN   = 3'd3;
    localparam logic [2:0] c_HALTED  = 3'd4;

    localparam logic [2:0] c_FLUSH_LOAD = 3'(FLUSH_CYCLES);

    logic [2:0]       state_q, state_d;
    logic [2:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;

    logic             w_load_use;
    logic             w_redir;
    logic             w_stall;
    logic             w_issue_nop;
    logic             w_jmp;
    logic [31:0]      w_jmp_pc;
    logic             w_bubble;
    logic             w_hold;
    logic             w_flush_id;
    logic             w_halt_ack;

    // The load in EX writes a register that the ID instruction actually reads
    assign w_load_use = bus.ex_valid & bus.ex_is_load & (bus.ex_rd != 5'd0) & bus.id_valid &
                        ((bus.id_uses_rs1 & (bus.id_rs1 == bus.ex_rd)) |
                         (bus.id_uses_rs2 & (bus.id_rs2 == bus.ex_rd)));

    // A redirect only counts once the EX unit has produced its result
    assign w_redir = bus.ex_valid & bus.ex_redirect & ~bus.ex_busy;

    // State and flush-window counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= c_RUN;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state selection; MC_WAIT falls back to RUN rules once busy drops
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            c_FLUSH: begin
                if (w_redir) begin
                    state_d = c_FLUSH;
                    cnt_d   = c_FLUSH_LOAD;
                end else if (cnt_q <= 3'd1) begin
                    state_d = c_RUN;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            c_DRAIN: begin
                if (!bus.halt_req) begin
                    // Abandoned halt: a redirect seen now still needs its NOP window
                    if (w_redir) begin
                        state_d = c_FLUSH;
                        cnt_d   = c_FLUSH_LOAD;
                    end else begin
                        state_d = c_RUN;
                    end
                end else if (!bus.ex_valid && !bus.ex_busy) begin
                    state_d = c_HALTED;
                end
            end
            c_HALTED: begin
                if (!bus.halt_req) begin
                    state_d = c_RUN;
                end
            end
            default: begin
                // RUN, and MC_WAIT (busy keeps it there, release re-evaluates as RUN)
                if (w_redir) begin
                    state_d = c_FLUSH;
                    cnt_d   = c_FLUSH_LOAD;
                end else if (bus.ex_busy) begin
                    state_d = c_MC_WAIT;
                end else if (w_load_use) begin
                    state_d = c_RUN;
                end else if (bus.halt_req) begin
                    state_d = c_DRAIN;
                end else begin
                    state_d = c_RUN;
                end
            end
        endcase
    end

    // Control outputs from state plus live inputs, all forced low during reset
    always_comb begin
        w_stall     = 1'b0;
        w_issue_nop = 1'b0;
        w_jmp       = 1'b0;
        w_bubble    = 1'b0;
        w_hold      = 1'b0;
        w_flush_id  = 1'b0;
        w_halt_ack  = 1'b0;
        w_jmp_pc    = 32'd0;
        if (!reset) begin
            case (state_q)
                c_FLUSH: begin
                    if (w_redir) begin
                        w_jmp      = 1'b1;
                        w_flush_id = 1'b1;
                        w_bubble   = 1'b1;
                    end else begin
                        w_issue_nop = 1'b1;
                        w_bubble    = 1'b1;
                    end
                end
                c_DRAIN: begin
                    w_stall  = 1'b1;
                    w_bubble = 1'b1;
                    if (w_redir) begin
                        w_jmp      = 1'b1;
                        w_flush_id = 1'b1;
                    end
                end
                c_HALTED: begin
                    w_halt_ack = 1'b1;
                    w_stall    = 1'b1;
                    w_bubble   = 1'b1;
                end
                default: begin
                    if (w_redir) begin
                        w_jmp      = 1'b1;
                        w_flush_id = 1'b1;
                        w_bubble   = 1'b1;
                    end else if (bus.ex_busy) begin
                        w_stall = 1'b1;
                        w_hold  = 1'b1;
                    end else if (w_load_use) begin
                        w_stall  = 1'b1;
                        w_bubble = 1'b1;
                    end else if (bus.halt_req) begin
                        w_stall  = 1'b1;
                        w_bubble = 1'b1;
                    end
                end
            endcase
        end
        // Target is only visible while jmp is asserted
        if (w_jmp) begin
            w_jmp_pc = bus.ex_target;
        end
    end

    // Performance counters: stall cycles and taken redirects, wrapping
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_q + CNT_W'(w_stall);
            flush_cnt_q <= flush_cnt_q + CNT_W'(w_jmp);
        end
    end

    assign bus.stall        = w_stall;
    assign bus.issue_nop    = w_issue_nop;
    assign bus.jmp          = w_jmp;
    assign bus.jmp_pc       = w_jmp_pc;
    assign bus.id_ex_bubble = w_bubble;
    assign bus.id_ex_hold   = w_hold;
    assign bus.flush_id     = w_flush_id;
    assign bus.halt_ack     = w_halt_ack;
    assign bus.stall_cnt    = stall_cnt_q;
    assign bus.flush_cnt    = flush_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_ctrl
// Description : Directed self-checking bench for hazard_ctrl; one instance
//               with a single-cycle flush window, one with a three-cycle one.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic        id_valid, id_uses_rs1, id_uses_rs2;
    logic [4:0]  id_rs1, id_rs2, ex_rd;
    logic        ex_valid, ex_is_load, ex_busy, ex_redirect, halt_req;
    logic [31:0] ex_target;

    hazard_ctrl_if #(.CNT_W(16)) bus1 ();
    hazard_ctrl_if #(.CNT_W(16)) bus3 ();

    hazard_ctrl #(.FLUSH_CYCLES(1), .CNT_W(16)) dut1 (.clk(clk), .reset(reset), .bus(bus1));
    hazard_ctrl #(.FLUSH_CYCLES(3), .CNT_W(16)) dut3 (.clk(clk), .reset(reset), .bus(bus3));

    assign bus1.id_valid = id_valid;       assign bus3.id_valid = id_valid;
    assign bus1.id_rs1 = id_rs1;           assign bus3.id_rs1 = id_rs1;
    assign bus1.id_rs2 = id_rs2;           assign bus3.id_rs2 = id_rs2;
    assign bus1.id_uses_rs1 = id_uses_rs1; assign bus3.id_uses_rs1 = id_uses_rs1;
    assign bus1.id_uses_rs2 = id_uses_rs2; assign bus3.id_uses_rs2 = id_uses_rs2;
    assign bus1.ex_valid = ex_valid;       assign bus3.ex_valid = ex_valid;
    assign bus1.ex_is_load = ex_is_load;   assign bus3.ex_is_load = ex_is_load;
    assign bus1.ex_rd = ex_rd;             assign bus3.ex_rd = ex_rd;
    assign bus1.ex_busy = ex_busy;         assign bus3.ex_busy = ex_busy;
    assign bus1.ex_redirect = ex_redirect; assign bus3.ex_redirect = ex_redirect;
    assign bus1.ex_target = ex_target;     assign bus3.ex_target = ex_target;
    assign bus1.halt_req = halt_req;       assign bus3.halt_req = halt_req;

    typedef struct packed {
        logic        stall;
        logic        nop;
        logic        jmp;
        logic        bub;
        logic        hold;
        logic        flush;
        logic        ack;
        logic [31:0] pc;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    function automatic exp_t mk(logic s, logic n, logic j, logic b, logic h,
                                logic f, logic a, logic [31:0] pc);
        exp_t e;
        e.stall = s; e.nop = n; e.jmp = j; e.bub = b;
        e.hold  = h; e.flush = f; e.ack = a; e.pc = pc;
        return e;
    endfunction

    function automatic exp_t observe(int sel);
        exp_t o;
        if (sel == 3) begin
            o = mk(bus3.stall, bus3.issue_nop, bus3.jmp, bus3.id_ex_bubble,
                   bus3.id_ex_hold, bus3.flush_id, bus3.halt_ack, bus3.jmp_pc);
        end else begin
            o = mk(bus1.stall, bus1.issue_nop, bus1.jmp, bus1.id_ex_bubble,
                   bus1.id_ex_hold, bus1.flush_id, bus1.halt_ack, bus1.jmp_pc);
        end
        return o;
    endfunction

    task automatic chk_out(string tag, exp_t obs, exp_t exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed={stall,nop,jmp,bub,hold,flush,ack}=%b pc=%h expected=%b pc=%h",
                   tag, obs[38:32], obs.pc, exp[38:32], exp.pc);
        end
    endtask

    task automatic chk_cnt(string tag, logic [15:0] obs, logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock: queue the expectation, sample mid-cycle, then step past the edge
    task automatic cyc(string tag, int sel, exp_t e);
        exp_t x;
        q.push_back(e);
        @(negedge clk);
        x = q.pop_front();
        chk_out(tag, observe(sel), x);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_valid = 0; id_uses_rs1 = 0; id_uses_rs2 = 0; id_rs1 = 0; id_rs2 = 0;
        ex_valid = 0; ex_is_load = 0; ex_rd = 0; ex_busy = 0; ex_redirect = 0;
        ex_target = 0; halt_req = 0;
    endtask

    localparam exp_t Z   = 39'd0;
    exp_t SB, NOPB, HB, ACK;

    initial begin
        SB   = mk(1, 0, 0, 1, 0, 0, 0, 32'h0);
        NOPB = mk(0, 1, 0, 1, 0, 0, 0, 32'h0);
        HB   = mk(1, 0, 0, 0, 1, 0, 0, 32'h0);
        ACK  = mk(1, 0, 0, 1, 0, 0, 1, 32'h0);

        // Reset with a live redirect and halt request: everything must stay quiet
        idle();
        reset = 1; ex_valid = 1; ex_redirect = 1; ex_target = 32'hDEAD; halt_req = 1;
        @(posedge clk); #1;
        cyc("reset1", 1, Z);
        cyc("reset3", 3, Z);
        chk_cnt("reset.stall_cnt", bus1.stall_cnt, 16'd0);
        chk_cnt("reset.flush_cnt", bus1.flush_cnt, 16'd0);
        reset = 0; idle();
        cyc("idle", 1, Z);

        // Load-use on rs1
        ex_valid = 1; ex_is_load = 1; ex_rd = 5; id_valid = 1; id_rs1 = 5; id_uses_rs1 = 1;
        cyc("lu_rs1", 1, SB);
        idle();
        cyc("lu_after", 1, Z);
        chk_cnt("lu.stall_cnt", bus1.stall_cnt, 16'd1);

        // x0 never creates a hazard
        ex_valid = 1; ex_is_load = 1; ex_rd = 0; id_valid = 1; id_rs1 = 0; id_uses_rs1 = 1;
        cyc("lu_x0", 1, Z);
        // Matching rs2 that is not read
        ex_rd = 9; id_rs1 = 3; id_rs2 = 9; id_uses_rs2 = 0;
        cyc("lu_rs2_unused", 1, Z);
        id_uses_rs2 = 1;
        cyc("lu_rs2", 1, SB);
        idle();

        // Redirect, single NOP cycle afterwards
        ex_valid = 1; ex_redirect = 1; ex_target = 32'h200;
        cyc("redir", 1, mk(0, 0, 1, 1, 0, 1, 0, 32'h200));
        idle();
        cyc("flush1", 1, NOPB);
        cyc("post_flush", 1, Z);
        chk_cnt("redir.flush_cnt", bus1.flush_cnt, 16'd1);

        // Four busy cycles with a redirect that must be ignored
        ex_valid = 1; ex_busy = 1; ex_redirect = 1; ex_target = 32'h300;
        for (int i = 0; i < 4; i++) cyc("busy", 1, HB);
        idle();
        cyc("busy_done", 1, Z);
        chk_cnt("busy.stall_cnt", bus1.stall_cnt, 16'd6);
        chk_cnt("busy.flush_cnt", bus1.flush_cnt, 16'd1);

        // Redirect together with load-use: redirect only
        ex_valid = 1; ex_is_load = 1; ex_rd = 7; ex_redirect = 1; ex_target = 32'h400;
        id_valid = 1; id_rs2 = 7; id_uses_rs2 = 1;
        cyc("redir_lu", 1, mk(0, 0, 1, 1, 0, 1, 0, 32'h400));
        idle();
        cyc("flush2", 1, NOPB);
        cyc("idle2", 1, Z);

        // Redirect taken in the same cycle the busy unit finishes
        ex_valid = 1; ex_busy = 1;
        cyc("busy1", 1, HB);
        ex_busy = 0; ex_redirect = 1; ex_target = 32'h500;
        cyc("mc_redir", 1, mk(0, 0, 1, 1, 0, 1, 0, 32'h500));
        idle();
        cyc("flush3", 1, NOPB);
        cyc("idle3", 1, Z);
        chk_cnt("mc.stall_cnt", bus1.stall_cnt, 16'd7);
        chk_cnt("mc.flush_cnt", bus1.flush_cnt, 16'd3);

        // Halt: drain while EX is occupied, then acknowledge
        halt_req = 1; ex_valid = 1;
        cyc("halt_req", 1, SB);
        cyc("drain1", 1, SB);
        ex_valid = 0;
        cyc("drain2", 1, SB);
        cyc("halted", 1, ACK);
        halt_req = 0;
        cyc("halt_drop", 1, ACK);
        cyc("resume", 1, Z);
        chk_cnt("halt.stall_cnt", bus1.stall_cnt, 16'd12);

        // Halt abandoned during drain
        halt_req = 1; ex_valid = 1;
        cyc("halt2", 1, SB);
        halt_req = 0;
        cyc("drain_abort", 1, SB);
        idle();
        cyc("abort_run", 1, Z);
        chk_cnt("abort.stall_cnt", bus1.stall_cnt, 16'd14);

        // Let the three-cycle instance return to RUN
        for (int i = 0; i < 4; i++) cyc("settle", 1, Z);

        // Reset in the middle of a three-cycle flush window
        ex_valid = 1; ex_redirect = 1; ex_target = 32'h600;
        cyc("r3_redir", 3, mk(0, 0, 1, 1, 0, 1, 0, 32'h600));
        idle();
        cyc("r3_flush", 3, NOPB);
        reset = 1;
        cyc("r3_in_reset", 3, Z);
        reset = 0;
        cyc("r3_after", 3, Z);
        chk_cnt("r3.stall_cnt", bus3.stall_cnt, 16'd0);
        chk_cnt("r3.flush_cnt", bus3.flush_cnt, 16'd0);
        cyc("r3_after2", 3, Z);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline sequencing controller for the RV32IC front end. It watches the ID and EX stages and drives the fetch stage's `stall`, `issue_nop`, `jmp` and `jmp_pc` inputs, plus bubble/hold controls for the ID/EX register. It resolves load-use hazards, EX-stage redirects with post-redirect flush, multi-cycle EX waits and debug halt/drain, and counts stall and flush events for performance monitoring.

## Interface
Parameters:
- `FLUSH_CYCLES`, default 1: cycles of `issue_nop` after a redirect; legal range 1..7.
- `CNT_W`, default 16: width of the performance counters.

Ports:
- `clk`  in  1  clock
- `reset`  in  1  reset, synchronous, active-high
- `id_valid`  in  1  ID holds a valid instruction
- `id_rs1`, `id_rs2`  in  5 each  ID source registers
- `id_uses_rs1`, `id_uses_rs2`  in  1 each  source is actually read
- `ex_valid`  in  1  EX holds a valid instruction
- `ex_is_load`  in  1  EX instruction is a load
- `ex_rd`  in  5  EX destination register
- `ex_busy`  in  1  multi-cycle EX unit not finished
- `ex_redirect`  in  1  branch/jump in EX is taken
- `ex_target`  in  32  redirect target PC
- `halt_req`  in  1  debug halt request (level)
- `stall`  out  1  to fetch: hold PC
- `issue_nop`  out  1  to fetch: replace instruction with NOP
- `jmp`  out  1  to fetch: load `jmp_pc`
- `jmp_pc`  out  32  redirect PC
- `id_ex_bubble`  out  1  load NOP into ID/EX register
- `id_ex_hold`  out  1  ID/EX and EX hold contents
- `flush_id`  out  1  invalidate IF/ID register
- `halt_ack`  out  1  core drained and halted
- `stall_cnt`  out  `CNT_W`  cycles with `stall`=1
- `flush_cnt`  out  `CNT_W`  redirects taken

## Operation
- **States:** RUN, FLUSH, MC_WAIT, DRAIN, HALTED. Reset state is RUN.
- **`load_use`** = `ex_valid & ex_is_load & ex_rd!=0 & id_valid & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd))`.
- **`redir`** = `ex_valid & ex_redirect & ~ex_busy`. `ex_redirect` is ignored while `ex_busy`=1.
- **Priority:** redir > ex_busy > load_use > halt_req.
- **RUN:**
  - redir: `jmp`=1, `jmp_pc`=`ex_target`, `flush_id`=1, `id_ex_bubble`=1. Next state is FLUSH with counter=`FLUSH_CYCLES`.
  - else ex_busy: `stall`=1, `id_ex_hold`=1. Next state is MC_WAIT.
  - else load_use: `stall`=1, `id_ex_bubble`=1 for this cycle only. Stay in RUN.
  - else halt_req: `stall`=1, `id_ex_bubble`=1. Next state is DRAIN.
- **FLUSH:**
  - `issue_nop`=1 and `id_ex_bubble`=1; counter decrements each cycle.
  - Return to RUN in the cycle after counter reaches 1.
  - A redir in FLUSH cannot occur because EX holds a bubble. If it is asserted anyway, it is honoured as in RUN and the counter reloads.
- **MC_WAIT:**
  - `stall`=1 and `id_ex_hold`=1 while `ex_busy`=1.
  - The first cycle with `ex_busy`=0 outputs nothing from this state and is evaluated with RUN rules, so a redir or load_use is handled in that same cycle.
  - Next state follows the RUN rules.
- **DRAIN:**
  - `stall`=1 and `id_ex_bubble`=1.
  - redir is honoured: `jmp`/`flush_id` asserted, state stays DRAIN.
  - Go to HALTED when `ex_valid`=0 and `ex_busy`=0.
  - If `halt_req` drops before HALTED, return to RUN.
- **HALTED:** `halt_ack`=1, `stall`=1, `id_ex_bubble`=1. When `halt_req`=0, go to RUN.
- **Counters:**
  - `stall_cnt` increments on every cycle with `stall`=1.
  - `flush_cnt` increments on every cycle with `jmp`=1.
  - Both wrap modulo 2^`CNT_W` and clear on reset.
- All outputs are combinational from the registered state and counter plus the current inputs; only state, counter and perf counters are flops.

## Timing
- Redirect has zero-cycle response: `jmp` is asserted in the same cycle `redir` is seen. The fetch PC equals `ex_target` at the next edge.
- `issue_nop` covers the synchronous imem latency: it is asserted for exactly `FLUSH_CYCLES` cycles starting the cycle after `jmp`.
- Load-use produces exactly one stall cycle. The load leaves EX at the next edge, so `load_use` clears without help.
- Reset values:
  - `stall`, `issue_nop`, `jmp`, `id_ex_bubble`, `id_ex_hold`, `flush_id`, `halt_ack` are 0 in reset cycles (outputs are forced while `reset`=1).
  - `jmp_pc` is 0.
  - Counters are 0.
- Reset asserted mid-FLUSH, MC_WAIT or DRAIN returns to RUN at the next edge with no residual pulses.
- When `jmp`=0, `jmp_pc` must be 0, so waveforms carry no stale target.

## Test plan
- **Load-use:** `ex_is_load`=1, `ex_rd`=5, ID `rs1`=5 used → one cycle of `stall`=1 and `id_ex_bubble`=1; `stall_cnt`=1.
- **Redirect:** `ex_redirect`=1, `ex_target`=0x200, `FLUSH_CYCLES`=1 → `jmp`=1 and `jmp_pc`=0x200 in the same cycle, `issue_nop`=1 the next cycle, `flush_cnt`=1.
- **Multi-cycle wait:** `ex_busy` high for 4 cycles → `stall`=1 and `id_ex_hold`=1 for exactly 4 cycles; a redirect asserted during busy is ignored.
- **Simultaneous events:** redirect with load_use in the same cycle → only the redirect response; no `stall` is asserted.
- **Halt:** `halt_req`=1 with `ex_valid`=1 for 2 cycles → DRAIN for 2 cycles, then `halt_ack`=1. Dropping `halt_req` → `halt_ack`=0 and `stall`=0 the next cycle.
- **Reset mid-operation:** reset during FLUSH (`FLUSH_CYCLES`=3, after 1 cycle) → all outputs are 0 the cycle after reset deasserts; counters are 0.
